vga_pattern_gen: RTL and testbench

Pixel source that sits directly upstream of the VGA timing controller. It drives the controller's `iR`/`iG`/`iB` inputs and consumes its `oDataRequest` strobe. It keeps its own active-area X/Y raster position, advancing once per request, and produces one of four test patterns selected per frame: colour bars, checkerboard, gradient, or bouncing square. The RGB value for the current position is presented combinationally, so it is valid in the same cycle that the controller samples it.

---
 rtl/vga_pkg.sv | 49 ++++
 rtl/vga_pattern_gen_if.sv | 41 ++++
 rtl/vga_square_mover.sv | 60 ++++++
 rtl/vga_pattern_gen.sv | 128 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel path.
// Active-area defaults match the timing controller.
package vga_pkg;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int SQ_SIZE_DEF    = 32;
  localparam int CHECK_LOG2_DEF = 5;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(
    input logic [2:0] idx
  );
    logic [23:0] c;
    c = C_BLACK;
    unique case (idx)
      3'd0: c = C_WHITE;
      3'd1: c = C_YELLOW;
      3'd2: c = C_CYAN;
      3'd3: c = C_GREEN;
      3'd4: c = C_MAGENTA;
      3'd5: c = C_RED;
      3'd6: c = C_BLUE;
      3'd7: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Pixel handshake between timing controller and pattern source.
// Master issues requests and mode; slave returns pixel and position.
interface vga_pattern_gen_if #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  logic          iDataRequest;
  logic [1:0]    iMode;
  logic [7:0]    oR;
  logic [7:0]    oG;
  logic [7:0]    oB;
  logic [XW-1:0] oX;
  logic [YW-1:0] oY;
  logic          oFrameStart;

  modport master (
    output iDataRequest,
    output iMode,
    input  oR,
    input  oG,
    input  oB,
    input  oX,
    input  oY,
    input  oFrameStart
  );

  modport slave (
    input  iDataRequest,
    input  iMode,
    output oR,
    output oG,
    output oB,
    output oX,
    output oY,
    output oFrameStart
  );

endinterface

// File: rtl/vga_square_mover.sv
// One axis of the bouncing square: steps once per enable,
// reflecting at 0 and MAX.
module vga_square_mover
  import vga_pkg::*;
#(
  parameter int MAX = 608
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_step,
  output logic [$clog2(MAX+1)-1:0]   o_pos,
  output dir_e                       o_dir
);

  localparam int PW = $clog2(MAX+1);

  logic [PW-1:0] r_pos;
  dir_e          r_dir;
  logic [PW-1:0] w_pos_nxt;
  dir_e          w_dir_nxt;

  // position/direction state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pos <= '0;
      r_dir <= DIR_POS;
    end else begin
      r_pos <= w_pos_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // next step: bounce off either limit, else move one pixel
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    if (i_step) begin
      unique case (1'b1)
        (r_dir == DIR_POS) && (r_pos == PW'(MAX)): begin
          w_dir_nxt = DIR_NEG;
          w_pos_nxt = PW'(MAX - 1);
        end
        (r_dir == DIR_NEG) && (r_pos == '0): begin
          w_dir_nxt = DIR_POS;
          w_pos_nxt = PW'(1);
        end
        (r_dir == DIR_POS) && (r_pos != PW'(MAX)): begin
          w_pos_nxt = r_pos + PW'(1);
        end
        (r_dir == DIR_NEG) && (r_pos != '0): begin
          w_pos_nxt = r_pos - PW'(1);
        end
      endcase
    end
  end

  assign o_pos = r_pos;
  assign o_dir = r_dir;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source feeding the VGA timing controller.
// Tracks raster position per request; RGB is combinational on state.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int SQ_SIZE    = SQ_SIZE_DEF,
  parameter int CHECK_LOG2 = CHECK_LOG2_DEF
) (
  input  logic               iClk,
  input  logic               iRst,
  vga_pattern_gen_if.slave   bus
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int XE    = XW + 1;
  localparam int YE    = YW + 1;
  localparam int MAXX  = H_ACTIVE - SQ_SIZE;
  localparam int MAXY  = V_ACTIVE - SQ_SIZE;
  localparam int SXW   = $clog2(MAXX + 1);
  localparam int SYW   = $clog2(MAXY + 1);
  localparam int BAR_W = H_ACTIVE / 8;

  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  mode_e          r_mode;
  logic [7:0]     r_frame;

  logic           w_x_end;
  logic           w_y_end;
  logic           w_frame_end;
  logic [SXW-1:0] w_sq_x;
  logic [SYW-1:0] w_sq_y;
  dir_e           w_dir_x;
  dir_e           w_dir_y;
  logic [1:0]     w_unused_dirs;
  logic [2:0]     w_bar_idx;
  logic           w_chk;
  logic [7:0]     w_grad_r;
  logic [7:0]     w_grad_g;
  logic           w_in_x;
  logic           w_in_y;
  logic [23:0]    w_rgb;

  assign w_x_end     = (r_x == XW'(H_ACTIVE - 1));
  assign w_y_end     = (r_y == YW'(V_ACTIVE - 1));
  assign w_frame_end = bus.iDataRequest & w_x_end & w_y_end;

  // raster position: one pixel per request, wrap at line/frame end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (bus.iDataRequest) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  // mode latch and frame counter, both only at frame end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_mode  <= MODE_BARS;
      r_frame <= 8'd0;
    end else if (w_frame_end) begin
      r_mode  <= mode_e'(bus.iMode);
      r_frame <= r_frame + 8'd1;
    end
  end

  vga_square_mover #(
    .MAX (MAXX)
  ) u_mover_x (
    .i_clk  (iClk),
    .i_rst  (iRst),
    .i_step (w_frame_end),
    .o_pos  (w_sq_x),
    .o_dir  (w_dir_x)
  );

  vga_square_mover #(
    .MAX (MAXY)
  ) u_mover_y (
    .i_clk  (iClk),
    .i_rst  (iRst),
    .i_step (w_frame_end),
    .o_pos  (w_sq_y),
    .o_dir  (w_dir_y)
  );

  // direction is kept for debug visibility only
  assign w_unused_dirs = {w_dir_x, w_dir_y};

  assign w_bar_idx = 3'(r_x / XW'(BAR_W));
  assign w_chk     = r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2];
  assign w_grad_r  = 8'(10'(r_x) >> 2);
  assign w_grad_g  = 8'(9'(r_y) >> 1);

  assign w_in_x = (XE'(r_x) >= XE'(w_sq_x)) &&
                  (XE'(r_x) <  XE'(w_sq_x) + XE'(SQ_SIZE));
  assign w_in_y = (YE'(r_y) >= YE'(w_sq_y)) &&
                  (YE'(r_y) <  YE'(w_sq_y) + YE'(SQ_SIZE));

  // colour select for the current raster position
  always_comb begin
    w_rgb = C_BLACK;
    unique case (r_mode)
      MODE_BARS:   w_rgb = bar_colour(w_bar_idx);
      MODE_CHECK:  w_rgb = w_chk ? C_BLACK : C_WHITE;
      MODE_GRAD:   w_rgb = {w_grad_r, w_grad_g, r_frame};
      MODE_SQUARE: w_rgb = (w_in_x && w_in_y) ? C_WHITE : C_BLUE;
    endcase
  end

  assign bus.oR          = w_rgb[23:16];
  assign bus.oG          = w_rgb[15:8];
  assign bus.oB          = w_rgb[7:0];
  assign bus.oX          = r_x;
  assign bus.oY          = r_y;
  assign bus.oFrameStart = (r_x == '0) && (r_y == '0);

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a reduced 32x8 raster.
// Stimulus queues directed expectations; a monitor checks each request.
module tb_vga_pattern_gen;

  localparam int TH  = 32;
  localparam int TV  = 8;
  localparam int TSQ = 4;
  localparam int TCL = 2;
  localparam int NPIX = TH * TV;

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] Y = 24'hFFFF00;
  localparam logic [23:0] C = 24'h00FFFF;
  localparam logic [23:0] G = 24'h00FF00;
  localparam logic [23:0] M = 24'hFF00FF;
  localparam logic [23:0] R = 24'hFF0000;
  localparam logic [23:0] B = 24'h0000FF;
  localparam logic [23:0] K = 24'h000000;

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  typedef struct {
    bit          chk;
    int          f;
    int          x;
    int          y;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.H_ACTIVE(TH), .V_ACTIVE(TV)) bus ();

  vga_pattern_gen #(
    .H_ACTIVE   (TH),
    .V_ACTIVE   (TV),
    .SQ_SIZE    (TSQ),
    .CHECK_LOG2 (TCL)
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  vec_t tbl[$];
  exp_t q[$];
  exp_t m_e;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] rgb_now();
    return {bus.oR, bus.oG, bus.oB};
  endfunction

  // scoreboard monitor: one expectation per request cycle
  always @(negedge clk) begin
    if (!rst && bus.iDataRequest === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'd0, 32'd1);
      end else begin
        m_e = q.pop_front();
        if (m_e.chk) begin
          check($sformatf("pos_f%0d(%0d,%0d)", m_e.f, m_e.x, m_e.y),
                {16'(bus.oX), 16'(bus.oY)},
                {16'(m_e.x), 16'(m_e.y)});
          check($sformatf("rgb_f%0d(%0d,%0d)", m_e.f, m_e.x, m_e.y),
                32'(rgb_now()), 32'(m_e.rgb));
        end
      end
    end
  end

  task automatic add(input int f, input int x, input int y,
                     input logic [23:0] rgb);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.rgb = rgb;
    tbl.push_back(v);
  endtask

  function automatic int find(input int f, input int x, input int y);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].f == f && tbl[i].x == x && tbl[i].y == y)
        return i;
    return -1;
  endfunction

  task automatic req(input bit chk, input int f, input int x,
                     input int y, input logic [23:0] rgb);
    exp_t e;
    e.chk = chk; e.f = f; e.x = x; e.y = y; e.rgb = rgb;
    q.push_back(e);
    bus.iDataRequest = 1'b1;
    @(posedge clk);
    #1;
    bus.iDataRequest = 1'b0;
  endtask

  task automatic gap(input int idx);
    repeat (2) begin
      @(negedge clk);
      check("gap_x", 32'(bus.oX), 32'(idx));
      check("gap_rgb", 32'(rgb_now()), 32'(idx < 4 ? W : Y));
      check("gap_fs", 32'(bus.oFrameStart), 32'(idx == 0));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input int f, input int npix);
    int x;
    int y;
    int k;
    for (int idx = 0; idx < npix; idx++) begin
      x = idx % TH;
      y = idx / TH;
      if (f == 0 && idx < 6) gap(idx);
      if (f == 1 && idx == 0) begin
        check("f1_start_x", 32'(bus.oX), 32'd0);
        check("f1_start_y", 32'(bus.oY), 32'd0);
        check("f1_start_fs", 32'(bus.oFrameStart), 32'd1);
      end
      k = find(f, x, y);
      req(k >= 0, f, x, y, (k >= 0) ? tbl[k].rgb : 24'h0);
      if (f == 0  && idx == 100) bus.iMode = 2'd1;
      if (f == 1  && idx == 50)  bus.iMode = 2'd2;
      if (f == 2  && idx == 10)  bus.iMode = 2'd3;
      if (f == 30 && idx == 5)   bus.iMode = 2'd2;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // frame 0: colour bars (4 px wide); mode change mid-frame ignored
    add(0, 0, 0, W); add(0, 1, 0, W); add(0, 2, 0, W);
    add(0, 3, 0, W); add(0, 4, 0, Y); add(0, 5, 0, Y);
    add(0, 8, 1, C); add(0, 12, 1, G); add(0, 16, 2, M);
    add(0, 20, 2, R); add(0, 24, 0, B); add(0, 27, 3, B);
    add(0, 28, 0, K); add(0, 4, 5, Y); add(0, 31, 7, K);
    // frame 1: checkerboard, 4 px cells
    add(1, 0, 0, W); add(1, 4, 0, K); add(1, 4, 4, W);
    add(1, 0, 4, K); add(1, 9, 5, K); add(1, 3, 3, W);
    // frame 2: gradient, frame counter 2
    add(2, 0, 0, 24'h000002); add(2, 31, 7, 24'h070302);
    add(2, 13, 4, 24'h030202);
    // square at (3,3), (4,4), (5,3)
    add(3, 3, 3, W); add(3, 6, 6, W); add(3, 2, 3, B);
    add(3, 7, 3, B); add(3, 3, 7, B); add(3, 3, 2, B);
    add(4, 4, 4, W); add(4, 4, 3, B); add(4, 7, 7, W);
    add(5, 5, 3, W); add(5, 5, 2, B); add(5, 8, 6, W);
    add(5, 5, 7, B);
    // square at (28,4), (27,3), (26,2): X bounce
    add(28, 28, 4, W); add(28, 27, 4, B); add(28, 31, 7, W);
    add(28, 28, 3, B);
    add(29, 27, 3, W); add(29, 30, 6, W); add(29, 31, 3, B);
    add(29, 26, 3, B);
    add(30, 26, 2, W); add(30, 30, 2, B); add(30, 29, 5, W);
    // frame 31: gradient, frame counter 31
    add(31, 0, 0, 24'h00001F); add(31, 19, 5, 24'h04021F);
    // after mid-frame reset: bars again from (0,0)
    add(100, 0, 0, W); add(100, 3, 0, W); add(100, 4, 0, Y);

    rst = 1'b1;
    bus.iDataRequest = 1'b0;
    bus.iMode = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_rgb", 32'(rgb_now()), 32'(W));
    check("rst_x", 32'(bus.oX), 32'd0);
    check("rst_y", 32'(bus.oY), 32'd0);
    check("rst_fs", 32'(bus.oFrameStart), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int f = 0; f <= 30; f++) run_frame(f, NPIX);
    run_frame(31, 180);

    #2;
    check("pre_arst_x", 32'(bus.oX), 32'd20);
    check("pre_arst_y", 32'(bus.oY), 32'd5);
    rst = 1'b1;
    #1;
    check("arst_rgb", 32'(rgb_now()), 32'(W));
    check("arst_x", 32'(bus.oX), 32'd0);
    check("arst_y", 32'(bus.oY), 32'd0);
    check("arst_fs", 32'(bus.oFrameStart), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frame(100, 8);
    @(negedge clk);
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
